imem_resp: RTL

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_resp.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imem_resp.sv
// Instruction-memory fetch responder: one outstanding request, programmable wait states, word-addressed load port.
// Define IMEM_RESP_FWD_EN to forward load writes into a pending fetch; leave it undefined to snapshot the word at acceptance.
module imem_resp #(
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_instr,
    output logic                  resp_err,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic        accept;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // A fetch faults when it is not word aligned or falls past the last word.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a[31:2] >> DEPTH_LOG2) != '0);
    endfunction

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        req_ready  = rst && (state == IDLE) && !flush;
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && addr_err(addr_q);
        resp_instr = (state == RESP) ? instr_q : NOP_INSTR;
    end

    // Fetch payload is captured at acceptance; forwarding keeps it coherent with later loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= 32'd0;
            instr_q <= NOP_INSTR;
        end else if (accept) begin
            addr_q <= req_addr;
            if (addr_err(req_addr)) begin
                instr_q <= NOP_INSTR;
`ifdef IMEM_RESP_FWD_EN
            end else if (wr_en && (wr_addr == req_addr[DEPTH_LOG2+1:2])) begin
                instr_q <= wr_data;
`endif
            end else begin
                instr_q <= mem[req_addr[DEPTH_LOG2+1:2]];
            end
`ifdef IMEM_RESP_FWD_EN
        end else if ((state == WAIT || state == RESP) && wr_en && !addr_err(addr_q)
                     && (wr_addr == addr_q[DEPTH_LOG2+1:2])) begin
            instr_q <= wr_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule
